// File: rtl/logicnet_io_pkg.sv
// rtl/logicnet_io_pkg.sv - shared types and helpers for the layer-0 input packer
// Purpose : packer FSM state type, index width helper, default feature width.
// Ports   : none (package).
package logicnet_io_pkg;

   localparam int DEFAULT_FEAT_W = 2;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      HOLD = 2'd1,
      DROP = 2'd2
   } packer_state_e;

   // Bits needed to index n features (n >= 2).
   function automatic int idx_width(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with asynchronous active-low clear
// Purpose : counts increment requests, holds at all-ones instead of wrapping.
// Ports   : clk, rst_n (async clear), i_inc (count request), o_cnt (current count).
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/layer0_input_packer.sv
// rtl/layer0_input_packer.sv - packs a stream of quantized features into one sample vector
// Purpose : collects N_FEAT features per frame into an assembly buffer, hands complete
//           samples to a separate output register (double-buffered), drops malformed frames.
// Ports   : clk, rst_n (async active-low)
//           s_valid/s_ready/s_data/s_last : feature input stream
//           m_valid/m_ready/m_data        : packed sample to layer 0, feature 0 in LSBs
//           err_short/err_long            : 1-cycle pulses for short / long frames
//           frame_cnt/drop_cnt            : saturating good / dropped frame counters
module layer0_input_packer
   import logicnet_io_pkg::*;
#(
   parameter int N_FEAT = 32,
   parameter int FEAT_W = DEFAULT_FEAT_W,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [FEAT_W-1:0]        s_data,
   input  logic                     s_last,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [N_FEAT*FEAT_W-1:0] m_data,
   output logic                     err_short,
   output logic                     err_long,
   output logic [CNT_W-1:0]         frame_cnt,
   output logic [CNT_W-1:0]         drop_cnt
);

   localparam int              IDX_W    = idx_width(N_FEAT);
   localparam int              VEC_W    = N_FEAT * FEAT_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

   packer_state_e     r_state;
   packer_state_e     w_nxt_state;
   logic [IDX_W-1:0]  r_idx;
   logic [IDX_W-1:0]  w_nxt_idx;
   logic [VEC_W-1:0]  r_buf;
   logic [VEC_W-1:0]  w_buf_beat;
   logic [VEC_W-1:0]  w_load_data;
   logic [VEC_W-1:0]  r_m_data;
   logic              r_m_valid;
   logic              r_err_short;
   logic              r_err_long;
   logic              r_started;
   logic              w_acc;
   logic              w_out_free;
   logic              w_wr_buf;
   logic              w_load;
   logic              w_short;
   logic              w_long;
   logic              w_frame_inc;
   logic              w_drop_inc;

   // r_started keeps s_ready low until the first edge after reset release.
   assign s_ready    = r_started && (r_state != HOLD);
   assign w_acc      = s_valid && s_ready;
   assign w_out_free = !r_m_valid || m_ready;

   // Assembly buffer with the current beat merged in at idx; used both for
   // ordinary writes and for loading a sample that completes this cycle.
   always_comb begin
      w_buf_beat = r_buf;
      w_buf_beat[int'(r_idx)*FEAT_W +: FEAT_W] = s_data;
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_idx   = r_idx;
      w_wr_buf    = 1'b0;
      w_load      = 1'b0;
      w_load_data = r_buf;
      w_short     = 1'b0;
      w_long      = 1'b0;
      w_frame_inc = 1'b0;
      w_drop_inc  = 1'b0;
      unique case (r_state)
         FILL: begin
            if (w_acc) begin
               if (r_idx != LAST_IDX) begin
                  if (s_last) begin
                     w_short    = 1'b1;
                     w_drop_inc = 1'b1;
                     w_nxt_idx  = '0;
                  end else begin
                     w_wr_buf  = 1'b1;
                     w_nxt_idx = r_idx + IDX_W'(1);
                  end
               end else if (s_last) begin
                  if (w_out_free) begin
                     w_load      = 1'b1;
                     w_load_data = w_buf_beat;
                     w_frame_inc = 1'b1;
                     w_nxt_idx   = '0;
                  end else begin
                     w_wr_buf    = 1'b1;
                     w_nxt_state = HOLD;
                  end
               end else begin
                  w_long      = 1'b1;
                  w_drop_inc  = 1'b1;
                  w_nxt_state = DROP;
               end
            end
         end
         HOLD: begin
            if (w_out_free) begin
               w_load      = 1'b1;
               w_frame_inc = 1'b1;
               w_nxt_idx   = '0;
               w_nxt_state = FILL;
            end
         end
         DROP: begin
            if (w_acc && s_last) begin
               w_nxt_idx   = '0;
               w_nxt_state = FILL;
            end
         end
         default: begin
            w_nxt_state = FILL;
            w_nxt_idx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= FILL;
         r_idx       <= '0;
         r_buf       <= '0;
         r_m_data    <= '0;
         r_m_valid   <= 1'b0;
         r_err_short <= 1'b0;
         r_err_long  <= 1'b0;
         r_started   <= 1'b0;
      end else begin
         r_started   <= 1'b1;
         r_state     <= w_nxt_state;
         r_idx       <= w_nxt_idx;
         r_err_short <= w_short;
         r_err_long  <= w_long;
         if (w_wr_buf) begin
            r_buf <= w_buf_beat;
         end
         if (w_load) begin
            r_m_data <= w_load_data;
         end
         // A reload on the same edge as the output handshake keeps m_valid high.
         if (w_load) begin
            r_m_valid <= 1'b1;
         end else if (m_ready) begin
            r_m_valid <= 1'b0;
         end
      end
   end

   assign m_valid   = r_m_valid;
   assign m_data    = r_m_data;
   assign err_short = r_err_short;
   assign err_long  = r_err_long;

   sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_frame_inc),
      .o_cnt (frame_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_drop_inc),
      .o_cnt (drop_cnt)
   );

endmodule

// File: tb/tb_layer0_input_packer.sv
// tb/tb_layer0_input_packer.sv - directed self-checking bench for layer0_input_packer
module tb_layer0_input_packer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid;
   logic        s_ready;
   logic [1:0]  s_data;
   logic        s_last;
   logic        m_valid;
   logic        m_ready;
   logic [7:0]  m_data;
   logic        err_short;
   logic        err_long;
   logic [15:0] frame_cnt;
   logic [15:0] drop_cnt;

   logic        d2_s_ready;
   logic        d2_m_valid;
   logic [7:0]  d2_m_data;
   logic        d2_err_short;
   logic        d2_err_long;
   logic [1:0]  d2_frame_cnt;
   logic [1:0]  d2_drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   layer0_input_packer #(.N_FEAT(4), .FEAT_W(2), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .err_short (err_short),
      .err_long  (err_long),
      .frame_cnt (frame_cnt),
      .drop_cnt  (drop_cnt)
   );

   layer0_input_packer #(.N_FEAT(4), .FEAT_W(2), .CNT_W(2)) dut_sat (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (d2_s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .m_valid   (d2_m_valid),
      .m_ready   (m_ready),
      .m_data    (d2_m_data),
      .err_short (d2_err_short),
      .err_long  (d2_err_long),
      .frame_cnt (d2_frame_cnt),
      .drop_cnt  (d2_drop_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one beat and returns #1 after the edge that accepted it.
   task automatic beat(input logic [1:0] d, input logic l);
      int w;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      w = 0;
      while (!s_ready && w < 20) begin
         step();
         w++;
      end
      if (w >= 20) begin
         n_tests++;
         n_fail++;
         $error("FAIL beat_timeout: observed s_ready=0 expected 1 within 20 cycles");
      end
      step();
   endtask

   task automatic idle();
      s_valid = 1'b0;
      s_last  = 1'b0;
      step();
   endtask

   task automatic frame(input logic [1:0] f0, input logic [1:0] f1,
                        input logic [1:0] f2, input logic [1:0] f3);
      beat(f0, 1'b0);
      beat(f1, 1'b0);
      beat(f2, 1'b0);
      beat(f3, 1'b1);
   endtask

   logic [1:0] t2_data [12];
   logic [7:0] t2_exp  [3];

   initial begin
      t2_data = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1};
      t2_exp  = '{8'hE4, 8'h39, 8'h4E};

      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = 2'd0;
      s_last  = 1'b0;
      m_ready = 1'b1;
      step();
      step();

      // Reset state
      chk("rst_s_ready",   s_ready,   1'b0);
      chk("rst_m_valid",   m_valid,   1'b0);
      chk("rst_m_data",    m_data,    8'h00);
      chk("rst_err_short", err_short, 1'b0);
      chk("rst_err_long",  err_long,  1'b0);
      chk("rst_frame_cnt", frame_cnt, 16'd0);
      chk("rst_drop_cnt",  drop_cnt,  16'd0);
      rst_n = 1'b1;
      step();
      chk("rel_s_ready", s_ready, 1'b1);

      // 1: single frame 1,2,3,0 -> 8'b00_11_10_01
      frame(2'd1, 2'd2, 2'd3, 2'd0);
      chk("t1_m_valid",   m_valid,   1'b1);
      chk("t1_m_data",    m_data,    8'h39);
      chk("t1_frame_cnt", frame_cnt, 16'd1);
      idle();
      chk("t1_m_valid_drop", m_valid, 1'b0);

      // 2: three back-to-back frames, no bubbles
      for (int i = 0; i < 12; i++) begin
         chk("t2_s_ready", s_ready, 1'b1);
         beat(t2_data[i], (i % 4) == 3);
         chk("t2_m_valid", m_valid, (i % 4) == 3);
         if ((i % 4) == 3) chk("t2_m_data", m_data, t2_exp[i / 4]);
      end
      chk("t2_frame_cnt", frame_cnt, 16'd4);
      idle();

      // 3: output stalled across two frames
      m_ready = 1'b0;
      frame(2'd3, 2'd3, 2'd0, 2'd0);
      chk("t3_a_valid", m_valid, 1'b1);
      chk("t3_a_data",  m_data,  8'h0F);
      frame(2'd1, 2'd0, 2'd1, 2'd0);
      s_valid = 1'b0;
      s_last  = 1'b0;
      chk("t3_hold_s_ready", s_ready,   1'b0);
      chk("t3_hold_data",    m_data,    8'h0F);
      chk("t3_hold_valid",   m_valid,   1'b1);
      chk("t3_hold_cnt",     frame_cnt, 16'd5);
      step();
      chk("t3_stall_data", m_data, 8'h0F);
      m_ready = 1'b1;
      step();
      chk("t3_b_valid",   m_valid,   1'b1);
      chk("t3_b_data",    m_data,    8'h11);
      chk("t3_b_cnt",     frame_cnt, 16'd6);
      chk("t3_b_s_ready", s_ready,   1'b1);
      step();
      chk("t3_b_drop", m_valid, 1'b0);

      // 4: short frame then good frame
      beat(2'd2, 1'b0);
      beat(2'd1, 1'b1);
      chk("t4_err_short", err_short, 1'b1);
      chk("t4_drop_cnt",  drop_cnt,  16'd1);
      chk("t4_m_valid",   m_valid,   1'b0);
      idle();
      chk("t4_err_short_clr", err_short, 1'b0);
      frame(2'd0, 2'd3, 2'd1, 2'd2);
      chk("t4_good_data", m_data,    8'h9C);
      chk("t4_good_cnt",  frame_cnt, 16'd7);
      idle();

      // 5: long frame of 6 beats
      beat(2'd1, 1'b0);
      beat(2'd1, 1'b0);
      beat(2'd1, 1'b0);
      chk("t5_no_err_early", err_long, 1'b0);
      beat(2'd1, 1'b0);
      chk("t5_err_long",  err_long, 1'b1);
      chk("t5_drop_cnt",  drop_cnt, 16'd2);
      beat(2'd1, 1'b0);
      chk("t5_err_long_clr", err_long, 1'b0);
      chk("t5_s_ready_drop", s_ready,  1'b1);
      beat(2'd1, 1'b1);
      chk("t5_m_valid", m_valid, 1'b0);
      frame(2'd3, 2'd2, 2'd1, 2'd0);
      chk("t5_good_data", m_data,    8'h1B);
      chk("t5_good_cnt",  frame_cnt, 16'd8);
      chk("t5_drop_keep", drop_cnt,  16'd2);
      idle();

      // 6a: reset mid-frame
      beat(2'd1, 1'b0);
      beat(2'd2, 1'b0);
      s_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6a_s_ready",   s_ready,   1'b0);
      chk("t6a_frame_cnt", frame_cnt, 16'd0);
      chk("t6a_drop_cnt",  drop_cnt,  16'd0);
      chk("t6a_m_data",    m_data,    8'h00);
      step();
      rst_n = 1'b1;
      step();

      // 6b: reset while holding
      m_ready = 1'b0;
      frame(2'd1, 2'd1, 2'd1, 2'd1);
      frame(2'd2, 2'd2, 2'd2, 2'd2);
      s_valid = 1'b0;
      s_last  = 1'b0;
      chk("t6b_hold_s_ready", s_ready, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6b_m_valid",   m_valid,   1'b0);
      chk("t6b_m_data",    m_data,    8'h00);
      chk("t6b_s_ready",   s_ready,   1'b0);
      chk("t6b_frame_cnt", frame_cnt, 16'd0);
      chk("t6b_err",       {err_short, err_long}, 2'b00);
      step();
      rst_n   = 1'b1;
      m_ready = 1'b1;
      step();
      chk("t6b_rel_s_ready", s_ready, 1'b1);
      frame(2'd2, 2'd2, 2'd1, 2'd1);
      chk("t6b_good_valid", m_valid,   1'b1);
      chk("t6b_good_data",  m_data,    8'h5A);
      chk("t6b_good_cnt",   frame_cnt, 16'd1);

      // 7: saturation on the CNT_W=2 instance
      frame(2'd0, 2'd0, 2'd0, 2'd1);
      frame(2'd0, 2'd0, 2'd0, 2'd2);
      chk("t7_sat_at3", d2_frame_cnt, 2'd3);
      frame(2'd0, 2'd0, 2'd0, 2'd3);
      frame(2'd1, 2'd0, 2'd0, 2'd0);
      chk("t7_wide_cnt", frame_cnt,    16'd5);
      chk("t7_sat_cnt",  d2_frame_cnt, 2'd3);
      chk("t7_last_data", m_data,      8'h01);
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
